pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch front end of the RV32I core.
- Holds the architectural PC and issues one instruction-memory request at a time.
- Buffers the returned instruction and hands {instr, pc} to decode.
- Computes PC+4 through the shared parameterized adder; redirects on branch/jump targets from execute.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/Adder.sv | 14 +
 rtl/pc_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states
//   INSTR_BYTES   : PC increment per sequential instruction
//   NOP_INSTR     : addi x0,x0,0, presented when no instruction is valid
//   fetch_pkt_t   : {instr, pc} pair handed to decode
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/Adder.sv
// Parameterized modulo-2^adder_size adder, shared by the core datapath.
//   a, b : operands
//   sum  : a + b, carry out discarded (wraps silently)
module Adder #(
  parameter int adder_size = 32
) (
  input  logic [adder_size-1:0] a,
  input  logic [adder_size-1:0] b,
  output logic [adder_size-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end of the RV32I core.
// Issues one instruction-memory request at a time, buffers the returned
// instruction and presents {instr, pc} to decode.
//
// Ports:
//   clk, reset            : core clock, synchronous active-high reset
//   stall_i               : decode back-pressure
//   redirect_valid_i/target_i : taken branch/jump and its target
//   imem_req_*            : request channel (valid/ready, address = pc)
//   imem_rsp_*            : response channel (valid, instruction word)
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : handoff to decode
//   pc_plus4_o            : pc + 4, link value for JAL/JALR
//   halted_o              : sticky misaligned-redirect error
//
// state | meaning
// BOOT  | one idle cycle after reset release
// REQ   | request for pc on the bus, waiting for ready
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction buffered, waiting for decode to take it
// HALT  | misaligned redirect seen, frozen until reset
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INSTR    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            halted_o
);

  import fetch_pkg::*;

  localparam logic [XLEN-1:0] PC_INCR = XLEN'(INSTR_BYTES);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_plus4;
  logic            kill, kill_nxt;
  logic            instr_valid_nxt;
  logic [31:0]     instr_nxt;
  logic [XLEN-1:0] instr_pc_nxt;
  logic            halted_nxt;
  logic            misaligned;
  logic            accept;

  Adder #(.adder_size(XLEN)) u_pc_adder (
    .a   (pc),
    .b   (PC_INCR),
    .sum (pc_plus4)
  );

  assign imem_req_valid_o = (state == REQ);
  assign imem_req_addr_o  = pc;
  assign pc_plus4_o       = pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      kill          <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= NOP_INSTR;
      instr_pc_o    <= RESET_VECTOR;
      halted_o      <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      kill          <= kill_nxt;
      instr_valid_o <= instr_valid_nxt;
      instr_o       <= instr_nxt;
      instr_pc_o    <= instr_pc_nxt;
      halted_o      <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    kill_nxt        = kill;
    instr_valid_nxt = instr_valid_o;
    instr_nxt       = instr_o;
    instr_pc_nxt    = instr_pc_o;
    halted_nxt      = halted_o;
    misaligned      = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
    accept          = instr_ready_i && !stall_i;

    // A misaligned target wins over everything; pc keeps its last good value.
    if (misaligned && state != HALT) begin
      state_nxt       = HALT;
      halted_nxt      = 1'b1;
      instr_valid_nxt = 1'b0;
      kill_nxt        = 1'b0;
    end else begin
      unique case (state)
        BOOT: state_nxt = REQ;
        REQ: begin
          if (redirect_valid_i) pc_nxt = redirect_target_i;
          if (imem_req_ready_i) begin
            // The accepted request used the old pc, so its data is stale.
            kill_nxt  = redirect_valid_i;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid_i) begin
            pc_nxt   = redirect_target_i;
            kill_nxt = 1'b1;
          end
          if (imem_rsp_valid_i) begin
            if (kill || redirect_valid_i) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              instr_nxt       = imem_rsp_data_i;
              instr_pc_nxt    = pc;
              instr_valid_nxt = 1'b1;
              state_nxt       = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid_i) begin
            instr_valid_nxt = 1'b0;
            instr_nxt       = NOP_INSTR;
            pc_nxt          = redirect_target_i;
            state_nxt       = REQ;
          end else if (accept) begin
            instr_valid_nxt = 1'b0;
            pc_nxt          = pc_plus4;
            state_nxt       = REQ;
          end
        end
        HALT: state_nxt = HALT;
        default: state_nxt = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [31:0] pc_plus4_o;
  logic        halted_o;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
    .pc_plus4_o(pc_plus4_o), .halted_o(halted_o)
  );

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  // Memory model knobs
  int mem_dly_min = 1;
  int mem_dly_max = 1;
  int ready_pct = 100;
  bit spurious_en = 1'b0;

  // Scoreboard: next instruction decode should receive, in program order
  fetch_pkt_t exp_q[$];
  bit sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  function automatic fetch_pkt_t mk_pkt(input logic [31:0] a);
    fetch_pkt_t p;
    p.instr = mem_word(a);
    p.pc    = a;
    return p;
  endfunction

  task automatic sb_restart(input logic [31:0] a);
    exp_q.delete();
    exp_q.push_back(mk_pkt(a));
  endtask

  // Instruction memory: one response per accepted request after a delay,
  // plus optional junk responses while a request is still pending acceptance.
  initial begin
    int mem_cnt;
    int pending;
    bit rsp_real;
    logic [31:0] mem_addr;
    mem_cnt = 0; pending = 0; rsp_real = 1'b0; mem_addr = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_cnt = 0;
        pending = 0;
      end else begin
        if (rsp_real) pending = 0;
        if (imem_req_valid_o && imem_req_ready_i) begin
          check("one_outstanding", pending, 0);
          pending  = 1;
          mem_addr = imem_req_addr_o;
          mem_cnt  = $urandom_range(mem_dly_max, mem_dly_min);
        end
      end
      @(posedge clk);
      #1;
      rsp_real = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = $urandom;
      if (!reset && mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = mem_word(mem_addr);
          rsp_real = 1'b1;
        end
      end else if (!reset && spurious_en && imem_req_valid_o && $urandom_range(0, 3) == 0) begin
        imem_rsp_valid_i = 1'b1;
      end
      imem_req_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: every instruction decode takes must be the next one in program order
  initial begin
    fetch_pkt_t item;
    forever begin
      @(negedge clk);
      if (sb_en && !reset && instr_valid_o && instr_ready_i && !stall_i && !redirect_valid_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual_pc=%h expected=queue_entry", instr_pc_o);
        end else begin
          item = exp_q.pop_front();
          check("sb_pc", instr_pc_o, item.pc);
          check("sb_instr", instr_o, item.instr);
          exp_q.push_back(mk_pkt(item.pc + 32'd4));
          accepted++;
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid_o && n < 50);
    check(name, instr_valid_o, 1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req_valid_o && n < 50);
    check(name, imem_req_valid_o, 1);
  endtask

  task automatic do_redirect(input logic [31:0] t, input bit aligned);
    @(posedge clk); #1;
    redirect_valid_i  = 1'b1;
    redirect_target_i = t;
    if (aligned) sb_restart(t);
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    reset = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_target_i = '0; instr_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid_o, 0);
    check("rst_instr_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, NOP_INSTR);
    check("rst_instr_pc", instr_pc_o, 32'h0);
    check("rst_pc_plus4", pc_plus4_o, 32'h4);
    check("rst_halted", halted_o, 0);

    // Sequential fetch: BOOT, then a REQ/WAIT/HOLD loop of three cycles
    @(posedge clk); #1;
    reset = 1'b0;
    sb_restart(32'h0);
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      check("seq_req_valid", imem_req_valid_o, (cyc % 3 == 1));
      if (cyc % 3 == 1) check("seq_req_addr", imem_req_addr_o, 32'(cyc / 3) * 32'd4);
      check("seq_instr_valid", instr_valid_o, (cyc % 3 == 0) && (cyc > 0));
      if ((cyc % 3 == 0) && (cyc > 0)) check("seq_instr_pc", instr_pc_o, 32'(cyc / 3 - 1) * 32'd4);
    end
    @(posedge clk); #1;
    mem_dly_min = 2; mem_dly_max = 2;
    @(negedge clk);
    check("seq_req_addr8", imem_req_addr_o, 32'h8);

    // Redirect while waiting for 0x8; response arrives a cycle later and is dropped
    @(posedge clk); #1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h100; stall_i = 1'b1;
    sb_restart(32'h100);
    @(negedge clk);
    check("redir_wait_req", imem_req_valid_o, 0);
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
    mem_dly_min = 1; mem_dly_max = 1;
    @(negedge clk);
    check("drop_no_req", imem_req_valid_o, 0);
    check("drop_no_valid", instr_valid_o, 0);
    @(negedge clk);
    check("redir_req_valid", imem_req_valid_o, 1);
    check("redir_req_addr", imem_req_addr_o, 32'h100);

    // Stall in HOLD: output frozen, no new request
    wait_valid("hold100_timeout");
    check("hold_instr", instr_o, 32'h0050_0093);
    check("hold_pc", instr_pc_o, 32'h100);
    check("hold_pc_plus4", pc_plus4_o, 32'h104);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", instr_valid_o, 1);
      check("stall_instr", instr_o, 32'h0050_0093);
      check("stall_pc", instr_pc_o, 32'h100);
      check("stall_no_req", imem_req_valid_o, 0);
    end
    @(posedge clk); #1;
    stall_i = 1'b0;
    @(posedge clk); #1;
    stall_i = 1'b1;
    @(negedge clk);
    check("post_stall_req", imem_req_valid_o, 1);
    check("post_stall_addr", imem_req_addr_o, 32'h104);
    wait_valid("hold104_timeout");
    check("hold104_pc", instr_pc_o, 32'h104);

    // Redirect and ready together in HOLD: redirect wins
    @(posedge clk); #1;
    stall_i = 1'b0; redirect_valid_i = 1'b1; redirect_target_i = 32'h200;
    sb_restart(32'h200);
    @(negedge clk);
    check("redir_hold_valid", instr_valid_o, 1);
    @(posedge clk); #1;
    redirect_valid_i = 1'b0; stall_i = 1'b1;
    @(negedge clk);
    check("redir_hold_req", imem_req_valid_o, 1);
    check("redir_hold_addr", imem_req_addr_o, 32'h200);
    check("redir_hold_nvalid", instr_valid_o, 0);
    check("redir_hold_nop", instr_o, NOP_INSTR);
    wait_valid("hold200_timeout");
    check("hold200_pc", instr_pc_o, 32'h200);

    // Wraparound at the top of the address space
    do_redirect(32'hFFFF_FFFC, 1'b1);
    wait_valid("holdwrap_timeout");
    check("wrap_pc", instr_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4_o, 32'h0);
    @(posedge clk); #1;
    stall_i = 1'b0;
    wait_req("wrap_req_timeout");
    check("wrap_next_addr", imem_req_addr_o, 32'h0);

    // Misaligned redirect halts; pc keeps its last value
    do_redirect(32'h102, 1'b0);
    @(negedge clk);
    check("halt_flag", halted_o, 1);
    check("halt_pc_kept", imem_req_addr_o, 32'h0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid_o || instr_valid_o || !halted_o) bad++;
    end
    check("halt_quiet", bad, 0);
    @(posedge clk); #1;
    reset = 1'b1; sb_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_halted", halted_o, 0);
    check("rst2_pc", imem_req_addr_o, 32'h0);
    check("rst2_pc_plus4", pc_plus4_o, 32'h4);
    check("rst2_valid", instr_valid_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_restart(32'h0);
    sb_en = 1'b1;

    // Randomized traffic against the program-order scoreboard
    mem_dly_min = 1; mem_dly_max = 3; ready_pct = 70; spurious_en = 1'b1;
    accepted = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      instr_ready_i = ($urandom_range(0, 3) != 0);
      stall_i       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 4) == 0)
          redirect_target_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        else
          redirect_target_i = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        redirect_valid_i = 1'b1;
        sb_restart(redirect_target_i);
      end else begin
        redirect_valid_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect_valid_i = 1'b0; stall_i = 1'b0; instr_ready_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rand_progress", (accepted > 100), 1);
    check("rand_no_halt", halted_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
